// File: rtl/cell_painter_pkg.sv
// Shared types, constants and helpers for the cell painter.
package cell_painter_pkg;

   // Grid geometry
   localparam int CELL_PX = 20;
   localparam int COLS    = 16;
   localparam int ROWS    = 12;

   // Pixel colour format used on the panel bus
   typedef logic [15:0] rgb565_t;

   localparam rgb565_t C_EMPTY  = 16'h0000;
   localparam rgb565_t C_HEAD   = 16'hFFE0;
   localparam rgb565_t C_BODY   = 16'h07E0;
   localparam rgb565_t C_APPLE  = 16'hF800;
   localparam rgb565_t C_BORDER = 16'h001F;
   localparam rgb565_t C_ERR    = 16'hF81F;

   // Object codes delivered by the scanner; 5..7 are treated as errors
   typedef enum logic [2:0] {
      OBJ_EMPTY  = 3'd0,
      OBJ_HEAD   = 3'd1,
      OBJ_BODY   = 3'd2,
      OBJ_APPLE  = 3'd3,
      OBJ_BORDER = 3'd4
   } obj_code_e;

   // Controller opcodes
   localparam logic [7:0] CASET = 8'h2A;
   localparam logic [7:0] PASET = 8'h2B;
   localparam logic [7:0] RAMWR = 8'h2C;

   // Pixel byte counter sizing
   localparam int PIX_BYTES = 2 * CELL_PX * CELL_PX;
   localparam int PIX_CNT_W = $clog2(PIX_BYTES);
   localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(PIX_BYTES - 1);
   localparam logic [PIX_CNT_W-1:0] CNT_ONE  = PIX_CNT_W'(1);

   // Sequencer states; each command/data state names the byte on the bus
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CASET_C = 3'd1,
      ST_CASET_D = 3'd2,
      ST_PASET_C = 3'd3,
      ST_PASET_D = 3'd4,
      ST_RAMWR_C = 3'd5,
      ST_PIXELS  = 3'd6,
      ST_DONE    = 3'd7
   } state_e;

   // Map an object code to its fill colour
   function automatic rgb565_t obj_colour(input logic [2:0] code);
      rgb565_t c;
      case (obj_code_e'(code))
         OBJ_EMPTY:  c = C_EMPTY;
         OBJ_HEAD:   c = C_HEAD;
         OBJ_BODY:   c = C_BODY;
         OBJ_APPLE:  c = C_APPLE;
         OBJ_BORDER: c = C_BORDER;
         default:    c = C_ERR;
      endcase
      return c;
   endfunction

   // Select one of the four address bytes: start H, start L, end H, end L
   function automatic logic [7:0] coord_byte(input logic [15:0] a0,
                                             input logic [15:0] a1,
                                             input logic [1:0]  idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = a0[15:8];
         2'd1:    b = a0[7:0];
         2'd2:    b = a1[15:8];
         default: b = a1[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cell_painter_lcd_byte_writer.sv
// Two-phase 8080 write strobe: one cycle with WRX low, one with WRX high,
// data and D/C held across both. ready is high whenever a new byte may be
// started in this cycle, so bytes can run back to back.
module lcd_byte_writer (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start,
   input  logic [7:0] byte_i,
   input  logic       dc,
   output logic       lcd_wrx,
   output logic [7:0] lcd_d,
   output logic       lcd_dcx,
   output logic       ready
);

   logic       wrx_q, wrx_d;
   logic [7:0] d_q, d_d;
   logic       dcx_q, dcx_d;
   logic       low_q, low_d;   // high during phase L

   // Next-value logic: a start loads the byte and drops the strobe
   always_comb begin
      d_d   = d_q;
      dcx_d = dcx_q;
      low_d = start & ~low_q;
      wrx_d = ~(start & ~low_q);
      if (start && !low_q) begin
         d_d   = byte_i;
         dcx_d = dc;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wrx_q <= 1'b1;
         d_q   <= 8'h00;
         dcx_q <= 1'b1;
         low_q <= 1'b0;
      end else begin
         wrx_q <= wrx_d;
         d_q   <= d_d;
         dcx_q <= dcx_d;
         low_q <= low_d;
      end
   end

   assign lcd_wrx = wrx_q;
   assign lcd_d   = d_q;
   assign lcd_dcx = dcx_q;
   assign ready   = ~low_q;

endmodule

// File: rtl/cell_painter.sv
// Paints one grid cell as a CELL_PX x CELL_PX RGB565 block on an 8080 TFT:
// CASET, PASET, RAMWR, then the pixel stream, then a cmd_done pulse.
module cell_painter
   import cell_painter_pkg::*;
(
   input  logic       clk,
   input  logic       nrst,
   input  logic       en_update,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [2:0] obj_code,
   output logic       cmd_done,
   output logic       busy,
   output logic       lcd_csx,
   output logic       lcd_dcx,
   output logic       lcd_wrx,
   output logic [7:0] lcd_d
);

   localparam logic [15:0] CELL_W = 16'(CELL_PX);
   localparam logic [3:0]  ROWS_W = 4'(ROWS);

   state_e                 state_q, state_d;
   logic [3:0]             x_q, x_d;
   logic [3:0]             y_q, y_d;
   rgb565_t                colour_q, colour_d;
   logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;

   logic                   wr_start;
   logic [7:0]             wr_byte;
   logic                   wr_dc;
   logic                   wr_ready;

   logic [15:0]            x0, x1, y0, y1;

   // Cell rectangle in panel coordinates
   assign x0 = {12'd0, x_q} * CELL_W;
   assign x1 = x0 + CELL_W - 16'd1;
   assign y0 = {12'd0, y_q} * CELL_W;
   assign y1 = y0 + CELL_W - 16'd1;

   lcd_byte_writer u_writer (
      .clk     (clk),
      .nrst    (nrst),
      .start   (wr_start),
      .byte_i  (wr_byte),
      .dc      (wr_dc),
      .lcd_wrx (lcd_wrx),
      .lcd_d   (lcd_d),
      .lcd_dcx (lcd_dcx),
      .ready   (wr_ready)
   );

   // Sequencer: picks the next byte whenever the writer can accept one
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      cnt_d    = cnt_q;
      wr_start = 1'b0;
      wr_byte  = 8'h00;
      wr_dc    = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (en_update) begin
               x_d      = x;
               y_d      = y;
               colour_d = obj_colour(obj_code);
               cnt_d    = '0;
               if (y >= ROWS_W) begin
                  // Row outside the grid: acknowledge without touching the bus
                  state_d = ST_DONE;
               end else begin
                  wr_start = 1'b1;
                  wr_byte  = CASET;
                  wr_dc    = 1'b0;
                  state_d  = ST_CASET_C;
               end
            end
         end
         ST_CASET_C: begin
            if (wr_ready) begin
               wr_start = 1'b1;
               wr_byte  = coord_byte(x0, x1, 2'd0);
               cnt_d    = '0;
               state_d  = ST_CASET_D;
            end
         end
         ST_CASET_D: begin
            if (wr_ready) begin
               wr_start = 1'b1;
               if (cnt_q[1:0] == 2'd3) begin
                  wr_byte = PASET;
                  wr_dc   = 1'b0;
                  state_d = ST_PASET_C;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  wr_byte = coord_byte(x0, x1, cnt_q[1:0] + 2'd1);
               end
            end
         end
         ST_PASET_C: begin
            if (wr_ready) begin
               wr_start = 1'b1;
               wr_byte  = coord_byte(y0, y1, 2'd0);
               cnt_d    = '0;
               state_d  = ST_PASET_D;
            end
         end
         ST_PASET_D: begin
            if (wr_ready) begin
               wr_start = 1'b1;
               if (cnt_q[1:0] == 2'd3) begin
                  wr_byte = RAMWR;
                  wr_dc   = 1'b0;
                  state_d = ST_RAMWR_C;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  wr_byte = coord_byte(y0, y1, cnt_q[1:0] + 2'd1);
               end
            end
         end
         ST_RAMWR_C: begin
            if (wr_ready) begin
               wr_start = 1'b1;
               wr_byte  = colour_q[15:8];
               cnt_d    = '0;
               state_d  = ST_PIXELS;
            end
         end
         ST_PIXELS: begin
            if (wr_ready) begin
               if (cnt_q == PIX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  // Even counter values are high bytes, so the next is the opposite half
                  wr_start = 1'b1;
                  cnt_d    = cnt_q + CNT_ONE;
                  wr_byte  = cnt_q[0] ? colour_q[15:8] : colour_q[7:0];
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         x_q      <= 4'd0;
         y_q      <= 4'd0;
         colour_q <= C_EMPTY;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign cmd_done = (state_q == ST_DONE);
   assign lcd_csx  = (state_q == ST_IDLE) || (state_q == ST_DONE);

endmodule

// File: doc/cell_painter.md
Name: cell_painter

Overview:
- Downstream of the grid scanner/diff stage.
- Takes one grid cell (x, y, obj_code) per en_update and paints it as a CELL_PX×CELL_PX RGB565 block on an 8080-style 8-bit parallel TFT controller (320×240, landscape).
- Sends the sequence CASET, PASET, RAMWR, then pixel data, and pulses cmd_done so the scanner can resume.

Parameters:
- CELL_PX, 20, pixel edge length of one grid cell
- COLS, 16, number of grid columns
- ROWS, 12, number of valid grid rows
- C_EMPTY, 16'h0000, colour for obj_code 000
- C_HEAD, 16'hFFE0, colour for 001
- C_BODY, 16'h07E0, colour for 010
- C_APPLE, 16'hF800, colour for 011
- C_BORDER, 16'h001F, colour for 100
- C_ERR, 16'hF81F, colour for 101..111

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset
- en_update  in  1  request to paint the cell given by x/y/obj_code
- x  in  4  grid column
- y  in  4  grid row
- obj_code  in  3  object code of the cell
- cmd_done  out  1  one-cycle pulse when the cell is finished or skipped
- busy  out  1  high while a request is in progress
- lcd_csx  out  1  chip select, active low
- lcd_dcx  out  1  0 = command byte, 1 = data byte
- lcd_wrx  out  1  write strobe; the panel latches on its rising edge
- lcd_d  out  8  parallel data bus

Behaviour:
- Interface: one clock, clk. Reset nrst is synchronous and active-low.
- Reset values: cmd_done=0, busy=0, lcd_csx=1, lcd_dcx=1, lcd_wrx=1, lcd_d=8'h00, FSM in IDLE. Reset is sampled every edge.
- Reset mid-transaction: outputs take their reset values at the next edge. No cmd_done is issued. lcd_csx returns high.
- IDLE: en_update is sampled at edge N. x, y and the colour mapped from obj_code are latched. en_update is ignored while busy (no queueing).
- Skip case: if y >= ROWS, no bus activity occurs. cmd_done=1 and busy=1 during cycle N+1, then back to IDLE.
- Geometry:
  - x0 = x*CELL_PX, x1 = x0+CELL_PX-1, y0 = y*CELL_PX, y1 = y0+CELL_PX-1.
  - All are 16-bit and sent MSB first.
  - Multiply by constant; no overflow for the defaults (max 319/239).
- Byte write takes 2 cycles:
  - Phase L: lcd_wrx=0, lcd_d and lcd_dcx valid.
  - Phase H: lcd_wrx=1, lcd_d and lcd_dcx held.
  - Bytes are back to back with no gap.
- Byte stream, 811 bytes total:
  - 2A(cmd), x0H, x0L, x1H, x1L
  - 2B(cmd), y0H, y0L, y1H, y1L
  - 2C(cmd)
  - CELL_PX² pixels of colour, high byte then low byte (800 data bytes)
- FSM states: IDLE → CASET_C → CASET_D(4) → PASET_C → PASET_D(4) → RAMWR_C → PIXELS → DONE → IDLE.
- PIXELS uses a byte counter 0..2*CELL_PX²-1. Its width is $clog2(2*CELL_PX²).
- Timing:
  - Phase L of the first byte is cycle N+1.
  - busy=1 and lcd_csx=0 from cycle N+1 through the last phase H (cycle N+1622).
  - DONE is cycle N+1623: cmd_done=1, busy=1, lcd_csx=1.
  - IDLE resumes at N+1624.
  - An en_update in cycle N+1623 is ignored.
- obj_code mapping uses the colour parameters above. Codes 101..111 map to C_ERR.

Decomposition:
- Shared package:
  - obj_code enum (EMPTY=0, HEAD=1, BODY=2, APPLE=3, BORDER=4)
  - controller opcodes CASET=8'h2A, PASET=8'h2B, RAMWR=8'h2C
  - FSM state typedef
  - rgb565_t typedef
- One sub-module, lcd_byte_writer: two-phase strobe generator.
  - Inputs: start, byte, dc.
  - Outputs: lcd_wrx, lcd_d, lcd_dcx, ready.
  - The top-level FSM sequences bytes through it.

Test Plan:
- Reset: hold nrst=0 for 2 cycles → cmd_done=0, busy=0, lcd_csx=1, lcd_wrx=1, lcd_dcx=1, lcd_d=00.
- Paint head at (4,4), one en_update pulse:
  - Expected bytes on lcd_wrx rising edges: 2A,00,50,00,63, 2B,00,50,00,63, 2C, then 800 bytes alternating FF,E0.
  - lcd_dcx=0 only on 2A, 2B, 2C.
  - cmd_done is a single pulse exactly 1623 cycles after the en_update edge.
- Corner cell (15,11), border: bytes 2A,01,2C,01,3F, 2B,00,DC,00,EF, 2C, then 400×(00,1F). lcd_csx is low for the whole stream.
- Invalid row: x=3, y=12 → zero lcd_wrx falling edges; cmd_done=1 on the next cycle; busy low afterwards.
- en_update re-asserted at cycles N+100 and N+1623 during a transaction → exactly one stream and one cmd_done. obj_code=3'b110 on the next request → pixel bytes F8,1F.
- nrst=0 at byte 300 of the pixel stream → next cycle lcd_csx=1, lcd_wrx=1, busy=0, no cmd_done. A following request to (0,0) restarts cleanly with 2A,00,00,00,13.
